pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Synthesizable N-channel PLL lock supervisor that replaces ad-hoc bench-side lock checking with on-chip supervision.
- Per channel: sequences the PLL reset, synchronizes the asynchronous lock, debounces lock acquisition, detects loss-of-lock, enforces a lock timeout and keeps sticky status plus a loss counter.
- Sits beside the PLL IP instances in the clock/reset subsystem and feeds the system reset generator and status registers.

Parameters:
- N_CH, 2, number of supervised PLL channels (1..8).
- RST_HOLD_CYCLES, 16, cycles pll_rst is held high per reset sequence (>=2).
- LOCK_STABLE_CYCLES, 64, consecutive synchronized-high lock cycles required before lock_ok (>=1).
- LOCK_TIMEOUT_CYCLES, 50000, maximum cycles from pll_rst release to lock_ok.
- CNT_W, 8, loss-counter width per channel.

Ports:
- clk  in  1  supervisor clock, free-running, independent of the PLL outputs.
- rst_n  in  1  asynchronous, active-low reset.
- lock_in  in  N_CH  raw PLL lock signals, asynchronous to clk.
- clear  in  1  single-cycle pulse: clear stickies and counters, restart FAIL channels.
- pll_rst  out  N_CH  active-high reset to each PLL.
- lock_ok  out  N_CH  debounced lock per channel.
- all_locked  out  1  AND of lock_ok, registered.
- loss_sticky  out  N_CH  a loss-of-lock has occurred since the last clear.
- timeout_sticky  out  N_CH  a lock timeout has occurred since the last clear.
- loss_cnt  out  N_CH*CNT_W  per-channel loss count, saturating; channel i occupies bits [i*CNT_W +: CNT_W].
- chk_ok  out  1  registered; all_locked & ~|loss_sticky & ~|timeout_sticky.

Behaviour:
- Reset (rst_n low, asynchronous) sets every output to 0 except pll_rst, which is all 1s. All FSMs go to RST_HOLD and all counters to 0.
- lock_in passes through a 2-flop synchronizer to give lock_s. A 3rd flop gives lock_d for edge detection. Latency from lock_in to lock_s is 2 clk cycles.
- Per-channel FSM states: RST_HOLD, WAIT_LOCK, STABLE, LOCKED, FAIL.
- RST_HOLD:
  - pll_rst=1.
  - Hold counter runs; after RST_HOLD_CYCLES cycles, go to WAIT_LOCK.
  - On that transition: pll_rst=0 and the timeout timer is zeroed.
- WAIT_LOCK:
  - lock_s=1 goes to STABLE with the stable counter at 1.
  - Timer reaching LOCK_TIMEOUT_CYCLES sets timeout_sticky and goes to FAIL.
- STABLE:
  - The stable counter increments while lock_s=1.
  - lock_s=0 returns to WAIT_LOCK. The timeout timer is NOT reset, so a glitching lock cannot evade the timeout.
  - When the counter reaches LOCK_STABLE_CYCLES, go to LOCKED; lock_ok is 1 on the next cycle.
  - Timeout expiry in STABLE behaves as in WAIT_LOCK.
- LOCKED:
  - lock_ok=1.
  - lock_s=0 triggers a loss event: lock_ok=0 next cycle, loss_sticky set, loss_cnt incremented (saturates at 2^CNT_W-1, no wrap).
  - After a loss event, go to WAIT_LOCK with the timer zeroed and pll_rst staying 0.
- FAIL:
  - pll_rst=1, lock_ok=0.
  - Terminal until clear, which moves the channel to RST_HOLD.
- clear:
  - Zeroes loss_sticky, timeout_sticky and loss_cnt for all channels.
  - Does not disturb channels that are not in FAIL.
- Simultaneous clear and event on the same cycle: the event wins. The sticky stays set and loss_cnt becomes 1.
- Simultaneous loss events on several channels are each counted independently.
- A timeout takes priority over a lock_s rise on the same cycle.
- all_locked and chk_ok lag lock_ok by 1 cycle.

Optional Feature:
- Macro: PLL_LOCK_AUTO_RETRY_EN.
- Defined:
  - A loss event or a timeout sends the channel to RST_HOLD instead of WAIT_LOCK or FAIL, so pll_rst is re-pulsed for RST_HOLD_CYCLES.
  - Stickies and loss_cnt update as normal.
  - FAIL is unreachable except via clear semantics.
- Undefined: behaviour as described in Behaviour.

Decomposition:
- Package pll_lock_pkg holds:
  - the FSM state enum;
  - the localparam counter widths, each derived via $clog2 of RST_HOLD_CYCLES, LOCK_STABLE_CYCLES and LOCK_TIMEOUT_CYCLES;
  - a saturating-increment function.
- Sub-module pll_lock_chan: the synchronizer, FSM, counters and stickies for one channel. It is instantiated N_CH times via generate.
- The top level holds only the all_locked / chk_ok reduction and the port packing.

Test Plan (N_CH=2, RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=100, CNT_W=4):
- Reset release, lock_in[0] rises 10 cycles after pll_rst[0] falls and stays high -> pll_rst[0] is 1 for 4 cycles. lock_ok[0] rises exactly 2+8+1 cycles after lock_in[0] rises. chk_ok=1 once both channels are locked.
- lock_in[1] held 0 -> timeout_sticky[1]=1 and pll_rst[1]=1 at cycle 100 after pll_rst[1] release. all_locked and chk_ok stay 0. Pulse clear -> channel 1 re-enters RST_HOLD.
- Channel 0 locked, lock_in[0] drops for 3 cycles -> lock_ok[0] falls 3 cycles after the drop. loss_sticky[0]=1, loss_cnt[0]=1. Relock occurs without pll_rst (macro off), or after a 4-cycle pll_rst pulse (macro on).
- 20 loss events on channel 0 -> loss_cnt[0] saturates at 15.
- clear asserted on the same cycle as a loss event -> loss_sticky[0]=1, loss_cnt[0]=1.
- lock_in[0] toggling 5 high / 1 low repeatedly -> lock_ok[0] never asserts. timeout_sticky[0]=1 at cycle 100.
- rst_n pulsed low mid-LOCKED -> outputs go to reset values immediately, asynchronously.

Source files
------------

// File: rtl/pll_lock_pkg.sv
// Shared types and helpers for the PLL lock supervisor: channel FSM state,
// default counter widths and a saturating increment.
package pll_lock_pkg;

    typedef enum logic [2:0] {
        StRstHold  = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StLocked   = 3'd3,
        StFail     = 3'd4
    } pll_state_e;

    localparam int unsigned DefRstHoldCycles    = 16;
    localparam int unsigned DefLockStableCycles = 64;
    localparam int unsigned DefLockTimeoutCycles = 50000;

    // Each counter must hold values up to its cycle count inclusive.
    localparam int unsigned HoldCntW    = $clog2(DefRstHoldCycles + 1);
    localparam int unsigned StableCntW  = $clog2(DefLockStableCycles + 1);
    localparam int unsigned TimeoutCntW = $clog2(DefLockTimeoutCycles + 1);

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// One supervised PLL channel: lock synchronizer, reset/lock FSM, timers and stickies.
// PLL_LOCK_AUTO_RETRY_EN: loss or timeout re-pulses the PLL reset instead of waiting/failing.
module pll_lock_chan
    import pll_lock_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = DefRstHoldCycles,
    parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
    parameter int unsigned CNT_W               = 8,
    parameter int unsigned HoldW               = HoldCntW,
    parameter int unsigned StableW             = StableCntW,
    parameter int unsigned TimerW              = TimeoutCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock_i,
    input  logic             clear_i,
    output logic             pll_rst_o,
    output logic             lock_ok_o,
    output logic             loss_sticky_o,
    output logic             timeout_sticky_o,
    output logic [CNT_W-1:0] loss_cnt_o
);

    localparam logic [HoldW-1:0]   HoldLast    = HoldW'(RST_HOLD_CYCLES - 1);
    localparam logic [StableW-1:0] StableLast  = StableW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);

    pll_state_e         state_q;
    logic [2:0]         sync_q;
    logic [HoldW-1:0]   hold_q;
    logic [StableW-1:0] stable_q;
    logic [TimerW-1:0]  timer_q;
    logic               pll_rst_q;
    logic               lock_ok_q;
    logic               loss_sticky_q;
    logic               timeout_sticky_q;
    logic [CNT_W-1:0]   loss_cnt_q;

    logic             lock_s;
    logic             lock_d;
    logic             lock_fall;
    logic [CNT_W-1:0] loss_base;
    logic [CNT_W-1:0] loss_next;

    assign lock_s    = sync_q[1];
    assign lock_d    = sync_q[2];
    assign lock_fall = lock_d & ~lock_s;
    // A loss on the same cycle as clear counts from zero, so the event survives the clear.
    assign loss_base = clear_i ? '0 : loss_cnt_q;
    assign loss_next = CNT_W'(sat_inc(32'(loss_base), CNT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StRstHold;
            sync_q           <= '0;
            hold_q           <= '0;
            stable_q         <= '0;
            timer_q          <= '0;
            pll_rst_q        <= 1'b1;
            lock_ok_q        <= 1'b0;
            loss_sticky_q    <= 1'b0;
            timeout_sticky_q <= 1'b0;
            loss_cnt_q       <= '0;
        end else begin
            sync_q <= {sync_q[1:0], lock_i};

            if (clear_i) begin
                loss_sticky_q    <= 1'b0;
                timeout_sticky_q <= 1'b0;
                loss_cnt_q       <= '0;
            end

            unique case (state_q)
                StRstHold: begin
                    pll_rst_q <= 1'b1;
                    lock_ok_q <= 1'b0;
                    if (hold_q == HoldLast) begin
                        state_q   <= StWaitLock;
                        pll_rst_q <= 1'b0;
                        hold_q    <= '0;
                        timer_q   <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end

                StWaitLock, StStable: begin
                    lock_ok_q <= 1'b0;
                    // Timer keeps running across STABLE->WAIT_LOCK so glitches cannot evade it.
                    if (timer_q == TimeoutLast) begin
                        timeout_sticky_q <= 1'b1;
                        pll_rst_q        <= 1'b1;
`ifdef PLL_LOCK_AUTO_RETRY_EN
                        state_q <= StRstHold;
                        hold_q  <= '0;
`else
                        state_q <= StFail;
`endif
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        if (!lock_s) begin
                            state_q <= StWaitLock;
                        end else if (state_q == StWaitLock) begin
                            stable_q <= StableW'(1);
                            state_q  <= (LOCK_STABLE_CYCLES == 1) ? StLocked : StStable;
                        end else begin
                            stable_q <= stable_q + 1'b1;
                            if (stable_q == StableLast) begin
                                state_q <= StLocked;
                            end
                        end
                    end
                end

                StLocked: begin
                    if (lock_fall) begin
                        lock_ok_q     <= 1'b0;
                        loss_sticky_q <= 1'b1;
                        loss_cnt_q    <= loss_next;
`ifdef PLL_LOCK_AUTO_RETRY_EN
                        state_q   <= StRstHold;
                        pll_rst_q <= 1'b1;
                        hold_q    <= '0;
`else
                        state_q <= StWaitLock;
                        timer_q <= '0;
`endif
                    end else begin
                        lock_ok_q <= 1'b1;
                    end
                end

                StFail: begin
                    pll_rst_q <= 1'b1;
                    lock_ok_q <= 1'b0;
                    if (clear_i) begin
                        state_q <= StRstHold;
                        hold_q  <= '0;
                    end
                end

                default: begin
                    state_q   <= StRstHold;
                    pll_rst_q <= 1'b1;
                    lock_ok_q <= 1'b0;
                    hold_q    <= '0;
                end
            endcase
        end
    end

    assign pll_rst_o        = pll_rst_q;
    assign lock_ok_o        = lock_ok_q;
    assign loss_sticky_o    = loss_sticky_q;
    assign timeout_sticky_o = timeout_sticky_q;
    assign loss_cnt_o       = loss_cnt_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// N-channel PLL lock supervisor: per-channel supervision plus registered summary status.
// PLL_LOCK_AUTO_RETRY_EN selects automatic PLL re-reset on loss/timeout in every channel.
module pll_lock_supervisor
    import pll_lock_pkg::*;
#(
    parameter int unsigned N_CH                = 2,
    parameter int unsigned RST_HOLD_CYCLES     = DefRstHoldCycles,
    parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
    parameter int unsigned CNT_W               = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       lock_in_i,
    input  logic                  clear_i,
    output logic [N_CH-1:0]       pll_rst_o,
    output logic [N_CH-1:0]       lock_ok_o,
    output logic                  all_locked_o,
    output logic [N_CH-1:0]       loss_sticky_o,
    output logic [N_CH-1:0]       timeout_sticky_o,
    output logic [N_CH*CNT_W-1:0] loss_cnt_o,
    output logic                  chk_ok_o
);

    localparam int unsigned HoldW   = cnt_width(RST_HOLD_CYCLES);
    localparam int unsigned StableW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TimerW  = cnt_width(LOCK_TIMEOUT_CYCLES);

    logic [N_CH-1:0] lock_ok;
    logic [N_CH-1:0] loss_sticky;
    logic [N_CH-1:0] timeout_sticky;
    logic            all_locked_q;
    logic            chk_ok_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        pll_lock_chan #(
            .RST_HOLD_CYCLES    (RST_HOLD_CYCLES),
            .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
            .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
            .CNT_W              (CNT_W),
            .HoldW              (HoldW),
            .StableW            (StableW),
            .TimerW             (TimerW)
        ) u_chan (
            .clk             (clk),
            .rst_n           (rst_n),
            .lock_i          (lock_in_i[i]),
            .clear_i         (clear_i),
            .pll_rst_o       (pll_rst_o[i]),
            .lock_ok_o       (lock_ok[i]),
            .loss_sticky_o   (loss_sticky[i]),
            .timeout_sticky_o(timeout_sticky[i]),
            .loss_cnt_o      (loss_cnt_o[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_locked_q <= 1'b0;
            chk_ok_q     <= 1'b0;
        end else begin
            all_locked_q <= &lock_ok;
            chk_ok_q     <= (&lock_ok) & ~(|loss_sticky) & ~(|timeout_sticky);
        end
    end

    assign lock_ok_o        = lock_ok;
    assign loss_sticky_o    = loss_sticky;
    assign timeout_sticky_o = timeout_sticky;
    assign all_locked_o     = all_locked_q;
    assign chk_ok_o         = chk_ok_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: expectations are queued with their due
// cycle and compared by a negedge monitor.
module tb_pll_lock_supervisor;

    localparam int SigPllRst   = 0;
    localparam int SigLockOk   = 1;
    localparam int SigAllLock  = 2;
    localparam int SigLossStk  = 3;
    localparam int SigTmoStk   = 4;
    localparam int SigLossCnt  = 5;
    localparam int SigChkOk    = 6;

    logic       clk;
    logic       rst_n;
    logic [1:0] lock_in;
    logic       clear;
    logic [1:0] pll_rst;
    logic [1:0] lock_ok;
    logic       all_locked;
    logic [1:0] loss_sticky;
    logic [1:0] timeout_sticky;
    logic [7:0] loss_cnt;
    logic       chk_ok;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int unsigned cyc;
        string       tag;
        int          id;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor #(
        .N_CH               (2),
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(100),
        .CNT_W              (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lock_in_i       (lock_in),
        .clear_i         (clear),
        .pll_rst_o       (pll_rst),
        .lock_ok_o       (lock_ok),
        .all_locked_o    (all_locked),
        .loss_sticky_o   (loss_sticky),
        .timeout_sticky_o(timeout_sticky),
        .loss_cnt_o      (loss_cnt),
        .chk_ok_o        (chk_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(input int id);
        case (id)
            SigPllRst:  return 32'(pll_rst);
            SigLockOk:  return 32'(lock_ok);
            SigAllLock: return 32'(all_locked);
            SigLossStk: return 32'(loss_sticky);
            SigTmoStk:  return 32'(timeout_sticky);
            SigLossCnt: return 32'(loss_cnt);
            SigChkOk:   return 32'(chk_ok);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input int unsigned dly, input int id, input logic [31:0] exp,
                             input string tag);
        exp_t e;
        e.cyc = cyc + dly;
        e.tag = tag;
        e.id  = id;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_val(sb[i].tag, obs(sb[i].id), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        lock_in = 2'b00;
        clear   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_pll_rst", obs(SigPllRst), 32'h3);
        check_val("rst_lock_ok", obs(SigLockOk), 32'h0);
        check_val("rst_loss_cnt", obs(SigLossCnt), 32'h0);
        check_val("rst_chk_ok", obs(SigChkOk), 32'h0);

        // Phase 1: reset release, lock acquisition, losses, clear and saturation
        tick(3);
        rst_n = 1'b1;
        expect_at(3, SigPllRst, 32'h3, "hold_pll_rst");
        expect_at(4, SigPllRst, 32'h0, "release_pll_rst");
        tick(14);
        lock_in = 2'b11;
        expect_at(10, SigLockOk, 32'h0, "lock_ok_early");
        expect_at(11, SigLockOk, 32'h3, "lock_ok_rise");
        expect_at(11, SigAllLock, 32'h0, "all_locked_lag");
        expect_at(12, SigAllLock, 32'h1, "all_locked_rise");
        expect_at(12, SigChkOk, 32'h1, "chk_ok_rise");
        tick(20);

        lock_in = 2'b10;
        expect_at(2, SigLockOk, 32'h3, "loss_lock_ok_hold");
        expect_at(3, SigLockOk, 32'h2, "loss_lock_ok_fall");
        expect_at(3, SigLossStk, 32'h1, "loss_sticky_set");
        expect_at(3, SigLossCnt, 32'h1, "loss_cnt_one");
        expect_at(4, SigChkOk, 32'h0, "loss_chk_ok");
`ifdef PLL_LOCK_AUTO_RETRY_EN
        expect_at(3, SigPllRst, 32'h1, "retry_pll_rst_set");
        expect_at(7, SigPllRst, 32'h0, "retry_pll_rst_rel");
        expect_at(15, SigLockOk, 32'h2, "relock_early");
        expect_at(16, SigLockOk, 32'h3, "relock_rise");
`else
        expect_at(6, SigPllRst, 32'h0, "relock_no_pll_rst");
        expect_at(13, SigLockOk, 32'h2, "relock_early");
        expect_at(14, SigLockOk, 32'h3, "relock_rise");
`endif
        tick(3);
        lock_in = 2'b11;
        tick(17);

        lock_in = 2'b10;
        tick(2);
        clear = 1'b1;
        expect_at(1, SigLossStk, 32'h1, "clr_loss_sticky");
        expect_at(1, SigLossCnt, 32'h1, "clr_loss_cnt");
        tick(1);
        clear   = 1'b0;
        lock_in = 2'b11;
        tick(17);

        clear = 1'b1;
        expect_at(1, SigLossStk, 32'h0, "clear_sticky");
        expect_at(1, SigLossCnt, 32'h0, "clear_cnt");
        expect_at(1, SigLockOk, 32'h3, "clear_keeps_lock");
        expect_at(2, SigChkOk, 32'h1, "clear_chk_ok");
        tick(1);
        clear = 1'b0;
        tick(4);

        for (int k = 1; k <= 20; k++) begin
            lock_in = 2'b10;
            expect_at(3, SigLossCnt, (k > 15) ? 32'd15 : 32'(k), $sformatf("sat_cnt_%0d", k));
            tick(3);
            lock_in = 2'b11;
            tick(17);
        end
        check_val("sat_tmo_sticky", obs(SigTmoStk), 32'h0);
        check_val("sat_chk_ok", obs(SigChkOk), 32'h0);
        check_val("pre_rst_lock_ok", obs(SigLockOk), 32'h3);

        #3 rst_n = 1'b0;
        #1;
        check_val("async_pll_rst", obs(SigPllRst), 32'h3);
        check_val("async_lock_ok", obs(SigLockOk), 32'h0);
        check_val("async_all_locked", obs(SigAllLock), 32'h0);
        check_val("async_loss_sticky", obs(SigLossStk), 32'h0);
        check_val("async_loss_cnt", obs(SigLossCnt), 32'h0);

        // Phase 2: channel 1 silent, channel 0 glitching 5 high / 1 low
        lock_in = 2'b00;
        tick(2);
        rst_n = 1'b1;
        expect_at(103, SigTmoStk, 32'h0, "tmo_before");
        expect_at(103, SigPllRst, 32'h0, "tmo_pll_rst_before");
        expect_at(104, SigTmoStk, 32'h3, "tmo_sticky");
        expect_at(104, SigPllRst, 32'h3, "tmo_pll_rst");
        expect_at(105, SigAllLock, 32'h0, "tmo_all_locked");
        expect_at(105, SigChkOk, 32'h0, "tmo_chk_ok");
`ifdef PLL_LOCK_AUTO_RETRY_EN
        expect_at(108, SigPllRst, 32'h0, "tmo_retry_rel");
`else
        expect_at(108, SigPllRst, 32'h3, "tmo_fail_hold");
`endif
        for (int t = 0; t < 110; t++) begin
            lock_in = {1'b0, (t % 6) != 5};
            if (t % 20 == 10) expect_at(0, SigLockOk, 32'h0, $sformatf("glitch_no_lock_%0d", t));
            tick(1);
        end
        lock_in = 2'b00;

`ifndef PLL_LOCK_AUTO_RETRY_EN
        tick(5);
        clear = 1'b1;
        expect_at(1, SigTmoStk, 32'h0, "fail_clear_sticky");
        expect_at(4, SigPllRst, 32'h3, "fail_rehold");
        expect_at(5, SigPllRst, 32'h0, "fail_rerelease");
        tick(1);
        clear = 1'b0;
        tick(4);
        lock_in = 2'b11;
        expect_at(11, SigLockOk, 32'h3, "fail_relock");
        expect_at(12, SigChkOk, 32'h1, "fail_relock_chk_ok");
`endif
        tick(20);

        check_val("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
